// File: rtl/pipe_elastic_stage_pkg.sv
// ============================================================================
// Module      : pipe_elastic_stage_pkg
// Description : Shared definitions for the NPC elastic pipeline registers:
//               core word size, per-boundary payload structs and widths,
//               performance counter width and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_elastic_stage_pkg;

  localparam int NPC_XLEN = 64;
  localparam int PERF_W   = 32;

  // Fetch -> decode payload
  typedef struct packed {
    logic [NPC_XLEN-1:0] pc;
    logic [31:0]         instr;
  } ifid_t;

  // Decode -> execute payload
  typedef struct packed {
    logic [NPC_XLEN-1:0] pc;
    logic [NPC_XLEN-1:0] rs1_val;
    logic [NPC_XLEN-1:0] rs2_val;
    logic [NPC_XLEN-1:0] imm;
    logic [4:0]          rd;
    logic [15:0]         ctrl;
  } idex_t;

  // Execute -> memory payload
  typedef struct packed {
    logic [NPC_XLEN-1:0] alu_res;
    logic [NPC_XLEN-1:0] rs2_val;
    logic [4:0]          rd;
    logic [15:0]         ctrl;
  } exmem_t;

  // Memory -> writeback payload
  typedef struct packed {
    logic [NPC_XLEN-1:0] wb_data;
    logic [4:0]          rd;
    logic                wen;
  } memwb_t;

  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_elastic_slot.sv
// ============================================================================
// Module      : pipe_elastic_slot
// Description : One elastic register slot. SKID=0 is a single register with
//               a combinational ready; SKID=1 adds a skid slot so the
//               upstream ready comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_elastic_slot
  import pipe_elastic_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occ
);

  if (SKID == 0) begin : g_plain

    logic             r_v;
    logic [WIDTH-1:0] r_data;
    logic             w_ready_up;
    logic             w_accept;

    // Slot can take a beat when empty or when its beat leaves this cycle
    assign w_ready_up = ~r_v | i_ready;
    assign w_accept   = i_valid & w_ready_up;

    // Single register: load on accept, empty on drain; flush kills the beat
    // but leaves the data register untouched
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v    <= 1'b0;
        r_data <= '0;
      end else if (flush) begin
        r_v    <= 1'b0;
      end else if (w_accept) begin
        r_v    <= 1'b1;
        r_data <= i_data;
      end else if (i_ready) begin
        r_v    <= 1'b0;
      end
    end

    assign o_ready = w_ready_up;
    assign o_valid = r_v;
    assign o_data  = r_data;
    assign o_occ   = {1'b0, r_v};

  end else begin : g_skid

    logic             r_m_v;
    logic             r_s_v;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;
    logic             w_accept;
    logic             w_m_free;

    // Upstream ready depends only on the skid flop, never on i_ready
    assign w_accept = i_valid & ~r_s_v;
    // Main slot is free this edge if empty or its beat is being taken
    assign w_m_free = ~r_m_v | i_ready;

    // Main/skid pair: skid only fills when main is stuck, and always
    // refills main before any new beat so order stays FIFO
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_m_v    <= 1'b0;
        r_s_v    <= 1'b0;
        r_m_data <= '0;
        r_s_data <= '0;
      end else if (flush) begin
        r_m_v    <= 1'b0;
        r_s_v    <= 1'b0;
      end else if (w_m_free) begin
        if (r_s_v) begin
          r_m_v    <= 1'b1;
          r_m_data <= r_s_data;
          r_s_v    <= 1'b0;
        end else if (w_accept) begin
          r_m_v    <= 1'b1;
          r_m_data <= i_data;
        end else begin
          r_m_v    <= 1'b0;
        end
      end else if (w_accept) begin
        r_s_v    <= 1'b1;
        r_s_data <= i_data;
      end
    end

    assign o_ready = ~r_s_v;
    assign o_valid = r_m_v;
    assign o_data  = r_m_data;
    assign o_occ   = {r_m_v & r_s_v, r_m_v ^ r_s_v};

  end

endmodule

`default_nettype wire

// File: rtl/pipe_elastic_stage.sv
// ============================================================================
// Module      : pipe_elastic_stage
// Description : Chain of NUM_STAGES elastic slots with valid/ready
//               handshake, synchronous flush, occupancy count and optional
//               stall/bubble counters (enabled by PIPE_ELASTIC_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_elastic_stage
  import pipe_elastic_stage_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int NUM_STAGES = 1,
  parameter  int SKID       = 0,
  localparam int OCC_W      = $clog2(NUM_STAGES*(1+SKID)+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);

  // Interface k sits between slot k-1 and slot k; 0 is upstream,
  // NUM_STAGES is downstream
  logic             w_valid [0:NUM_STAGES];
  logic             w_ready [0:NUM_STAGES];
  logic [WIDTH-1:0] w_data  [0:NUM_STAGES];
  logic [1:0]       w_occ   [0:NUM_STAGES-1];
  logic [OCC_W-1:0] w_occ_sum;

  assign w_valid[0]          = in_valid;
  assign w_data[0]           = in_data;
  assign in_ready            = w_ready[0];
  assign out_valid           = w_valid[NUM_STAGES];
  assign out_data            = w_data[NUM_STAGES];
  assign w_ready[NUM_STAGES] = out_ready;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    pipe_elastic_slot #(
      .WIDTH (WIDTH),
      .SKID  (SKID)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .i_valid (w_valid[gi]),
      .o_ready (w_ready[gi]),
      .i_data  (w_data[gi]),
      .o_valid (w_valid[gi+1]),
      .i_ready (w_ready[gi+1]),
      .o_data  (w_data[gi+1]),
      .o_occ   (w_occ[gi])
    );
  end

  // Occupancy is the total number of valid bits across all slots
  always_comb begin
    w_occ_sum = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_occ_sum = w_occ_sum + OCC_W'(w_occ[i]);
    end
  end

  assign occupancy = w_occ_sum;

`ifdef PIPE_ELASTIC_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_bubble_cnt;

  // Saturating stall/bubble counters; flush zeroes them with no count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready) begin
        r_stall_cnt <= perf_sat_inc(r_stall_cnt);
      end
      if (~out_valid) begin
        r_bubble_cnt <= perf_sat_inc(r_bubble_cnt);
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_elastic_stage.md
Name: pipe_elastic_stage

Overview:
- Parametrised pipeline register chain replacing the bare enable-gated stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the NPC core.
- Provides valid/ready handshaking, a per-chain synchronous flush for branch redirect, and an optional skid buffer so in_ready is registered.
- Instantiated once per inter-stage boundary, with the stage payload packed into one vector.

Parameters:
- WIDTH, 64: payload bits per beat.
- NUM_STAGES, 1: cascaded register slots (1..8); minimum latency in cycles.
- SKID, 0: 0 = plain elastic register (combinational in_ready); 1 = 2-entry skid slot per stage (registered in_ready).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of every in-flight beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  chain accepts beat this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head beat present.
- out_ready  in  1  downstream accepts head beat.
- out_data  out  WIDTH  head payload.
- occupancy  out  $clog2(NUM_STAGES*(1+SKID)+1)  beats currently held.
- stall_cnt  out  32  perf counter (see Optional Feature).
- bubble_cnt  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all valid bits 0, all data registers 0; out_valid=0, out_data=0, in_ready=1, occupancy=0, counters 0.
- Transfer occurs on a clock edge where valid&ready are both 1 at that interface. Stage i output feeds stage i+1 input; stage NUM_STAGES-1 drives out_*.
- SKID=0 stage:
  - ready_up = ~v | ready_dn (combinational).
  - On accept, data <= in, v <= 1.
  - Else if ready_dn, v <= 0.
  - Full throughput; a ready path runs combinationally through the whole chain.
- SKID=1 stage (main slot M, skid slot S):
  - ready_up = ~S.v, registered.
  - Accept while M empty, or while M drains: data goes to M.
  - Accept while M full and ready_dn=0: data goes to S.
  - When M drains and S is valid: M <= S, S.v <= 0.
  - Ordering is strictly FIFO; no combinational path from out_ready to in_ready.
- Latency: a beat accepted at edge t is visible on out_* after edge t+NUM_STAGES-1, i.e. NUM_STAGES cycles of register delay, when out_ready is held 1.
- Payload is never modified. Data registers do not load when no beat is accepted; they hold the old value.
- Flush (highest priority):
  - At the edge with flush=1, every valid bit clears. Any beat accepted in that same cycle is discarded.
  - The upstream still sees in_ready per the normal rule, so it may drop its beat.
  - After that edge, occupancy=0 and in_ready=1.
  - Flush with out_valid&out_ready: the head beat counts as transferred (downstream consumed it).
  - Data registers are not cleared by flush.
- Simultaneous accept and drain on a full stage: passes through with no bubble (both modes).
- occupancy equals the count of set valid bits, updated at each edge. It never exceeds NUM_STAGES*(1+SKID).
- Async reset mid-transfer: the beat is lost and the chain is empty immediately.

Optional Feature:
- Macro: PIPE_ELASTIC_PERF_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments every cycle with out_valid=0 & flush=0.
  - Both saturate at 32'hFFFF_FFFF and clear on rst or flush (flush clears them at that edge, with no increment that cycle).
- Undefined: both ports are tied to 0 and no counter flops are synthesised. Port list is unchanged.

Decomposition:
- Shared package:
  - NPC_XLEN=64.
  - Stage payload widths: IFID_W, IDEX_W, EXMEM_W, MEMWB_W.
  - Payload struct typedefs packed per boundary.
  - Perf counter width constant (32).
- Sub-module pipe_elastic_slot: one stage, both SKID variants selected by generate. The top is a generate loop chaining NUM_STAGES slots plus occupancy/perf logic.

Test Plan:
1. NUM_STAGES=3, SKID=0, out_ready=1; drive beats 0x11, 0x22, 0x33 back-to-back -> out_data shows 0x11, 0x22, 0x33 on consecutive cycles, first one 3 cycles after the first accept; occupancy peaks at 3.
2. SKID=1, NUM_STAGES=1; fill with 0xA then 0xB while out_ready=0 -> in_ready falls the cycle after 0xB is stored, occupancy=2. Raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after S drains.
3. NUM_STAGES=4 holding 4 beats; pulse flush with in_valid=1 and in_data=0xDEAD -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0xDEAD never appears at the output.
4. Random in_valid/out_ready (70%/60%) over 10,000 cycles with a scoreboard -> in-order delivery, no loss or duplication, out_data stable while out_valid&~out_ready.
5. Assert rst for 1 cycle while 2 beats are in flight, asynchronous to clk -> out_valid and out_data go to 0 before the next edge; no beat emerges after release.
6. With PIPE_ELASTIC_PERF_EN, hold one beat at the head with out_ready=0 for 5 cycles -> stall_cnt=5. Then flush -> stall_cnt=0, bubble_cnt=0. Without the macro -> both 0 throughout.
